// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential add/sub unit.
// FSM state encoding and counter sizing.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice.
// Exposes the carry into the slice MSB for overflow detection.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor, DIGIT bits per cycle, LSB digit first.
// Start/busy/done handshake with carry, overflow and zero flags.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  state_t state, nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q, ovf_q, zero_q;

  logic             load, step, last;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0] res_nxt;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sr[DIGIT-1:0]),
    .b        (b_sr[DIGIT-1:0]),
    .cin      (carry),
    .sum      (dsum),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  // Sum digits enter from the MSB side so the LSB digit lands at bit 0.
  assign cat     = {dsum, res};
  assign res_nxt = cat[WIDTH+DIGIT-1:DIGIT];
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt  = RUN;
          load = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        if (start) begin
          nxt  = RUN;
          load = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      res   <= res_nxt;
      carry <= dcout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_q <= dcout;
        ovf_q  <= dcmsb ^ dcout;
        zero_q <= (res_nxt == '0);
      end
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
